tile_job_scheduler: RTL
=======================

Name: tile_job_scheduler

Overview:
- Shares one pixel_processor between NUM_REQ triangle-setup requesters.
- Each requester streams per-tile jobs in non-decreasing tile order. pixel_processor flushes its tile buffers whenever the tile index increases, so the scheduler merges the streams into one globally tile-ordered job stream.
- At end of frame it emits a null job so the last real tile is flushed.
- Sits between the setup units and the pixel_processor input handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TILE_BITS, `TILE_ROWS_BITS+`TILE_COLUMNS_BITS, linear tile index width {tile_y,tile_x}.
- PAYLOAD_BITS, 256, opaque job payload (edges, deltas, z, color), passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- frame_start  in  1  one-cycle pulse; begins a frame
- req_vld  in  NUM_REQ  per-requester job valid
- req_rdy  out  NUM_REQ  per-requester job accepted
- req_tile  in  NUM_REQ*TILE_BITS  per-requester job tile index
- req_payload  in  NUM_REQ*PAYLOAD_BITS  per-requester job payload
- req_done  in  NUM_REQ  level; requester has no more jobs this frame
- job_vld  out  1  job to pixel_processor valid
- job_rdy  in  1  pixel_processor rdy_in
- job_tile  out  TILE_BITS  job tile index
- job_payload  out  PAYLOAD_BITS  job payload
- job_null  out  1  flush-only job; downstream forces all edges negative
- frame_done  out  1  one-cycle pulse after the null job is accepted
- order_err  out  1  sticky; a requester presented a tile below cur_tile

Behaviour:
- Reset values: state=IDLE, cur_tile=0, rr_ptr=0, done_seen=0, job_vld=0, job_tile=0, job_payload=0, job_null=0, frame_done=0, order_err=0, req_rdy=0. Reset mid-frame abandons all jobs; no flush is issued.
- State IDLE: req_rdy=0. On frame_start: go to RUN, cur_tile=0, done_seen=0, order_err=0.
- done_seen[i] sets when req_done[i] is high and req_vld[i] is low. It clears only on frame_start or rst.
- Output slot is a single register. The slot is free when !job_vld || job_rdy. job_vld clears on job_rdy when nothing new is loaded.
- State RUN:
  - eligible[i] = req_vld[i] && req_tile[i]==cur_tile.
  - When the slot is free and any eligible[i]: pick the first eligible index at or after rr_ptr, wrapping. Assert req_rdy for that index only, same cycle, combinational. Load the slot the next edge with job_null=0. Set rr_ptr = winner+1 mod NUM_REQ.
  - Latency is one cycle from requester handshake to job_vld. Throughput is 1 job/cycle while job_rdy=1.
  - Stale job: req_vld[i] && req_tile[i]<cur_tile. Accept it with req_rdy[i]=1, drop it, set order_err. Stale jobs take priority over eligible jobs in the same cycle; lowest index first. Dropping does not use the slot.
  - Advance: no eligible job, no stale job, and every i is either done_seen[i] or (req_vld[i] && req_tile[i]>cur_tile). Then cur_tile = minimum req_tile over valid requesters. This costs one cycle with no grant.
  - Stall: a requester with !req_vld && !done_seen holds the scheduler at cur_tile indefinitely. There is no timeout.
  - Frame end: all done_seen and the slot free. Load the null job: job_null=1, job_tile=cur_tile+1 saturated at all-ones, payload=0. Go to FLUSH.
- State FLUSH: hold the null job until job_rdy. Then pulse frame_done for one cycle and go to IDLE.
- frame_start outside IDLE is ignored.
- An output job never changes while job_vld && !job_rdy.
- Simultaneous req_done[i] and req_vld[i]: the job is still served; done_seen sets only once req_vld drops.
- Tile compare is unsigned over TILE_BITS. cur_tile never decreases within a frame.

Decomposition:
- raster_pkg (shared): TILE_IDX_BITS constant, job_t packed struct {tile, null, payload}, sched_state_t enum {IDLE, RUN, FLUSH}.
- Sub-module rr_arbiter (NUM_REQ parameter): inputs req mask and rr_ptr; outputs one-hot grant and grant index; purely combinational.
- Minimum-tile reduction stays inline as a function.

Test Plan:
- Single requester with tiles 0,0,3, job_rdy=1 -> job_tile sequence 0,0,3. One advance cycle before tile 3. Null job with job_tile=4, then frame_done pulse.
- Four requesters all presenting tile 2, rr_ptr=1 after reset plus one grant -> grants in order 1,2,3,0. Each job_vld one cycle after its req_rdy.
- Requester 0 on tile 5, requester 1 on tiles 1 then 5 -> output order 1,5,5. Requester 0 req_rdy stays low until cur_tile=5.
- job_rdy held low 10 cycles with job_vld=1 -> job_tile and job_payload stable. All req_rdy=0. No job lost or duplicated.
- After cur_tile=4, requester 2 presents tile 2 -> accepted and dropped, order_err=1, no output job produced.
- rst asserted mid-RUN with job_vld=1 -> next cycle job_vld=0, state IDLE. req_rdy=0 until the next frame_start.

Source files
------------

// File: rtl/raster_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// raster_pkg : shared tile-index widths, job record and scheduler state type.
// Rev 1.0
// ----------------------------------------------------------------------------
package raster_pkg;

   localparam int TILE_ROWS_BITS    = 4;
   localparam int TILE_COLUMNS_BITS = 4;
   localparam int TILE_IDX_BITS     = TILE_ROWS_BITS + TILE_COLUMNS_BITS;
   localparam int JOB_PAYLOAD_BITS  = 256;

   typedef struct packed {
      logic [TILE_IDX_BITS-1:0]    tile;
      logic                        is_null;
      logic [JOB_PAYLOAD_BITS-1:0] payload;
   } job_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick of the first request at/after ptr.
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PTR_W-1:0]   grant_idx_o
);

   always_comb begin : p_arb
      logic found;
      int   j;
      found       = 1'b0;
      j           = 0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_i[j]) begin
            found       = 1'b1;
            grant_o[j]  = 1'b1;
            grant_idx_o = PTR_W'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tile_job_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tile_job_scheduler : merges per-requester tile-ordered job streams into one
// globally tile-ordered stream and closes each frame with a null flush job.
// Rev 1.0
// ----------------------------------------------------------------------------
module tile_job_scheduler
   import raster_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int TILE_BITS    = TILE_IDX_BITS,
   parameter int PAYLOAD_BITS = JOB_PAYLOAD_BITS
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            frame_start,
   input  logic [NUM_REQ-1:0]              req_vld,
   output logic [NUM_REQ-1:0]              req_rdy,
   input  logic [NUM_REQ*TILE_BITS-1:0]    req_tile,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
   input  logic [NUM_REQ-1:0]              req_done,
   output logic                            job_vld,
   input  logic                            job_rdy,
   output logic [TILE_BITS-1:0]            job_tile,
   output logic [PAYLOAD_BITS-1:0]         job_payload,
   output logic                            job_null,
   output logic                            frame_done,
   output logic                            order_err
);

   localparam int PTR_W = $clog2(NUM_REQ);

   sched_state_t             state_q, state_d;
   logic [TILE_BITS-1:0]     cur_tile_q, cur_tile_d;
   logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]       done_seen_q, done_seen_d;
   logic                     job_vld_q, job_vld_d;
   logic [TILE_BITS-1:0]     job_tile_q, job_tile_d;
   logic [PAYLOAD_BITS-1:0]  job_payload_q, job_payload_d;
   logic                     job_null_q, job_null_d;
   logic                     frame_done_q, frame_done_d;
   logic                     order_err_q, order_err_d;

   logic [NUM_REQ-1:0]       elig, stale, stale_oh, ahead_ok, grant_oh;
   logic [PTR_W-1:0]         grant_idx;
   logic [PAYLOAD_BITS-1:0]  grant_payload;
   logic                     slot_free;

   function automatic logic [TILE_BITS-1:0] min_valid_tile(
      input logic [NUM_REQ-1:0]           vld,
      input logic [NUM_REQ*TILE_BITS-1:0] tiles
   );
      logic [TILE_BITS-1:0] m;
      m = '1;
      for (int i = 0; i < NUM_REQ; i++)
         if (vld[i] && tiles[i*TILE_BITS +: TILE_BITS] < m)
            m = tiles[i*TILE_BITS +: TILE_BITS];
      return m;
   endfunction

   always_comb begin : p_classify
      elig          = '0;
      stale         = '0;
      ahead_ok      = '0;
      grant_payload = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i]     = req_vld[i] && (req_tile[i*TILE_BITS +: TILE_BITS] == cur_tile_q);
         stale[i]    = req_vld[i] && (req_tile[i*TILE_BITS +: TILE_BITS] <  cur_tile_q);
         ahead_ok[i] = done_seen_q[i] ||
                       (req_vld[i] && (req_tile[i*TILE_BITS +: TILE_BITS] > cur_tile_q));
         if (grant_oh[i]) grant_payload = req_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
   end

   // Lowest-index stale requester is isolated as a one-hot mask.
   assign stale_oh  = stale & (~stale + NUM_REQ'(1));
   assign slot_free = !job_vld_q || job_rdy;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req_i       (elig),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant_oh),
      .grant_idx_o (grant_idx)
   );

   always_comb begin : p_next
      state_d       = state_q;
      cur_tile_d    = cur_tile_q;
      rr_ptr_d      = rr_ptr_q;
      done_seen_d   = done_seen_q;
      job_vld_d     = job_vld_q && !job_rdy;
      job_tile_d    = job_tile_q;
      job_payload_d = job_payload_q;
      job_null_d    = job_null_q;
      frame_done_d  = 1'b0;
      order_err_d   = order_err_q;
      req_rdy       = '0;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d     = RUN;
               cur_tile_d  = '0;
               done_seen_d = '0;
               order_err_d = 1'b0;
            end
         end
         RUN: begin
            done_seen_d = done_seen_q | (req_done & ~req_vld);
            if (|stale) begin
               req_rdy     = stale_oh;
               order_err_d = 1'b1;
            end else if (|elig) begin
               if (slot_free) begin
                  req_rdy       = grant_oh;
                  job_vld_d     = 1'b1;
                  job_tile_d    = cur_tile_q;
                  job_payload_d = grant_payload;
                  job_null_d    = 1'b0;
                  rr_ptr_d      = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
               end
            end else if (&done_seen_q) begin
               if (slot_free) begin
                  job_vld_d     = 1'b1;
                  job_tile_d    = (cur_tile_q == '1) ? cur_tile_q : cur_tile_q + TILE_BITS'(1);
                  job_payload_d = '0;
                  job_null_d    = 1'b1;
                  state_d       = FLUSH;
               end
            end else if ((&ahead_ok) && (|req_vld)) begin
               cur_tile_d = min_valid_tile(req_vld, req_tile);
            end
         end
         FLUSH: begin
            if (job_rdy) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cur_tile_q    <= '0;
         rr_ptr_q      <= '0;
         done_seen_q   <= '0;
         job_vld_q     <= 1'b0;
         job_tile_q    <= '0;
         job_payload_q <= '0;
         job_null_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         order_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_tile_q    <= cur_tile_d;
         rr_ptr_q      <= rr_ptr_d;
         done_seen_q   <= done_seen_d;
         job_vld_q     <= job_vld_d;
         job_tile_q    <= job_tile_d;
         job_payload_q <= job_payload_d;
         job_null_q    <= job_null_d;
         frame_done_q  <= frame_done_d;
         order_err_q   <= order_err_d;
      end
   end

   assign job_vld     = job_vld_q;
   assign job_tile    = job_tile_q;
   assign job_payload = job_payload_q;
   assign job_null    = job_null_q;
   assign frame_done  = frame_done_q;
   assign order_err   = order_err_q;

endmodule
`default_nettype wire
